nap_countdown: RTL and testbench

//  Downstream consumer of the keypad time-select stage. Captures the selected BCD time
//  (min : ten-sec : sec) when setting completes, then counts down to 0:00 at 1 Hz.

---
 rtl/nap_countdown_pkg.sv | 52 +++++
 rtl/nap_countdown_sec_tick_gen.sv | 27 ++
 rtl/nap_countdown.sv | 118 +++++++++++
 tb/tb_nap_countdown.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nap_countdown_pkg.sv
// rtl/nap_countdown_pkg.sv - state encoding, BCD limits and time helpers for the nap timer
package nap_countdown_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] SEC_MAX = 4'd9;
  localparam logic [3:0] TEN_MAX = 4'd5;
  localparam logic [3:0] MIN_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] ten;
    logic [3:0] sec;
  } bcd_time_t;

  function automatic bcd_time_t clamp_time(input logic [3:0] m, input logic [3:0] t,
                                           input logic [3:0] s);
    bcd_time_t r;
    r.min = (m > MIN_MAX) ? MIN_MAX : m;
    r.ten = (t > TEN_MAX) ? TEN_MAX : t;
    r.sec = (s > SEC_MAX) ? SEC_MAX : s;
    return r;
  endfunction

  // Only called with a non-zero time, so minutes never underflow.
  function automatic bcd_time_t dec_time(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec == 4'd0) begin
      r.sec = SEC_MAX;
      if (t.ten == 4'd0) begin
        r.ten = TEN_MAX;
        r.min = t.min - 4'd1;
      end else begin
        r.ten = t.ten - 4'd1;
      end
    end else begin
      r.sec = t.sec - 4'd1;
    end
    return r;
  endfunction

  function automatic logic is_zero(input bcd_time_t t);
    return (t.min == 4'd0) && (t.ten == 4'd0) && (t.sec == 4'd0);
  endfunction

endpackage

// File: rtl/nap_countdown_sec_tick_gen.sv
// rtl/nap_countdown_sec_tick_gen.sv - 1 Hz prescaler with clear and hold
module sec_tick_gen #(
  parameter int CLK_HZ = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !hold && !clr && (cnt == CNT_MAX);

endmodule

// File: rtl/nap_countdown.sv
// rtl/nap_countdown.sv - BCD nap countdown with pause, cancel and timed wake alarm
module nap_countdown
  import nap_countdown_pkg::*;
#(
  parameter int CLK_HZ    = 1000,
  parameter int ALARM_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] one_sec_in,
  input  logic [3:0] ten_sec_in,
  input  logic [3:0] one_min_in,
  input  logic       pause_btn,
  input  logic       cancel,
  input  logic       ack,
  output logic [3:0] one_sec,
  output logic [3:0] ten_sec,
  output logic [3:0] one_min,
  output logic       running,
  output logic       paused,
  output logic       alarm,
  output logic       done
);

  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SEC - 1);

  state_t    state;
  bcd_time_t cur;
  bcd_time_t cap;
  bcd_time_t nxt;
  logic [3:0] alarm_cnt;
  logic       load_q;
  logic       load_edge;
  logic       tick;

  assign load_edge = load & ~load_q;
  assign cap       = clamp_time(one_min_in, ten_sec_in, one_sec_in);
  assign nxt       = dec_time(cur);

  // Prescaler free-runs in RUN and ALARM; a (re)capture restarts the second.
  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clock (clock),
    .reset (reset),
    .clr   (cancel | load_edge),
    .hold  ((state == S_IDLE) || (state == S_PAUSE)),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cur       <= '0;
      alarm_cnt <= '0;
      load_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      load_q <= load;
      done   <= 1'b0;
      if (cancel) begin
        state     <= S_IDLE;
        cur       <= '0;
        alarm_cnt <= '0;
      end else if (load_edge) begin
        cur       <= cap;
        alarm_cnt <= '0;
        if (is_zero(cap)) begin
          state <= S_ALARM;
          done  <= 1'b1;
        end else begin
          state <= S_RUN;
        end
      end else begin
        case (state)
          S_RUN: begin
            if (tick) begin
              cur <= nxt;
              if (is_zero(nxt)) begin
                state     <= S_ALARM;
                done      <= 1'b1;
                alarm_cnt <= '0;
              end else if (pause_btn) begin
                state <= S_PAUSE;
              end
            end else if (pause_btn) begin
              state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (pause_btn) state <= S_RUN;
          end
          S_ALARM: begin
            if (ack) begin
              state     <= S_IDLE;
              alarm_cnt <= '0;
            end else if (tick) begin
              if (alarm_cnt == ALARM_LAST) begin
                state     <= S_IDLE;
                alarm_cnt <= '0;
              end else begin
                alarm_cnt <= alarm_cnt + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign one_sec = cur.sec;
  assign ten_sec = cur.ten;
  assign one_min = cur.min;
  assign running = (state == S_RUN);
  assign paused  = (state == S_PAUSE);
  assign alarm   = (state == S_ALARM);

endmodule

// File: tb/tb_nap_countdown.sv
// tb/tb_nap_countdown.sv - scoreboard bench for nap_countdown at CLK_HZ=4, ALARM_SEC=2
module tb_nap_countdown;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] one_sec_in, ten_sec_in, one_min_in;
  logic       pause_btn, cancel, ack;
  logic [3:0] one_sec, ten_sec, one_min;
  logic       running, paused, alarm, done;

  nap_countdown #(.CLK_HZ(4), .ALARM_SEC(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .one_sec_in (one_sec_in),
    .ten_sec_in (ten_sec_in),
    .one_min_in (one_min_in),
    .pause_btn  (pause_btn),
    .cancel     (cancel),
    .ack        (ack),
    .one_sec    (one_sec),
    .ten_sec    (ten_sec),
    .one_min    (one_min),
    .running    (running),
    .paused     (paused),
    .alarm      (alarm),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] v;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] ev(input logic [3:0] m, input logic [3:0] t,
                                     input logic [3:0] s, input logic r, input logic p,
                                     input logic a, input logic d);
    return {m, t, s, r, p, a, d};
  endfunction

  function automatic logic [15:0] run_v(input logic [3:0] m, input logic [3:0] t,
                                        input logic [3:0] s);
    return ev(m, t, s, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] pause_v(input logic [3:0] m, input logic [3:0] t,
                                          input logic [3:0] s);
    return ev(m, t, s, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] alarm_v(input logic d);
    return ev(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, d);
  endfunction

  localparam logic [15:0] IDLE_V = 16'h0000;

  // Monitor: compares every expectation whose cycle stamp has arrived.
  always @(negedge clock) begin
    logic [15:0] got;
    got = {one_min, ten_sec, one_sec, running, paused, alarm, done};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_checks++;
        if (q[i].cyc < cyc)
          $display("FAIL %s: check for cycle %0d missed at cycle %0d", q[i].name, q[i].cyc, cyc);
        else if (got !== q[i].v)
          $display("FAIL %s @%0d: got %h required %h (min,ten,sec,run,pause,alarm,done)",
                   q[i].name, cyc, got, q[i].v);
        else
          n_pass++;
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int t, input string nm, input logic [15:0] v);
    q.push_back('{t, nm, v});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic set_time(input logic [3:0] m, input logic [3:0] t, input logic [3:0] s);
    one_min_in = m;
    ten_sec_in = t;
    one_sec_in = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    reset = 1'b1; load = 1'b0; pause_btn = 1'b0; cancel = 1'b0; ack = 1'b0;
    set_time(4'd0, 4'd0, 4'd0);
    step();
    expect_at(cyc, "reset", IDLE_V);
    step();
    reset = 1'b0;
    step();

    // zero capture goes straight to alarm, which expires after two ticks
    load = 1'b1; c = cyc;
    expect_at(c + 1, "t1_alarm_done", alarm_v(1'b1));
    expect_at(c + 2, "t1_done_drop", alarm_v(1'b0));
    expect_at(c + 8, "t1_alarm_last", alarm_v(1'b0));
    expect_at(c + 9, "t1_expired", IDLE_V);
    goto(c + 10);
    pause_btn = 1'b1; ack = 1'b1;
    expect_at(c + 11, "t1_idle_ignores", IDLE_V);
    step();
    pause_btn = 1'b0; ack = 1'b0; load = 1'b0;
    step();

    // 0:30 full countdown
    set_time(4'd0, 4'd3, 4'd0); load = 1'b1; c = cyc;
    expect_at(c + 1, "t2_capture", run_v(4'd0, 4'd3, 4'd0));
    expect_at(c + 4, "t2_pre_tick", run_v(4'd0, 4'd3, 4'd0));
    expect_at(c + 5, "t2_first_dec", run_v(4'd0, 4'd2, 4'd9));
    expect_at(c + 41, "t2_0_20", run_v(4'd0, 4'd2, 4'd0));
    expect_at(c + 45, "t2_0_19", run_v(4'd0, 4'd1, 4'd9));
    expect_at(c + 120, "t2_0_01", run_v(4'd0, 4'd0, 4'd1));
    expect_at(c + 121, "t2_alarm_done", alarm_v(1'b1));
    expect_at(c + 122, "t2_alarm", alarm_v(1'b0));
    goto(c + 122);
    load = 1'b0;
    step();

    // 1:00 double borrow, then ack
    set_time(4'd1, 4'd0, 4'd0); load = 1'b1; c = cyc;
    expect_at(c + 1, "t3_capture", run_v(4'd1, 4'd0, 4'd0));
    expect_at(c + 5, "t3_borrow", run_v(4'd0, 4'd5, 4'd9));
    expect_at(c + 9, "t3_0_58", run_v(4'd0, 4'd5, 4'd8));
    expect_at(c + 240, "t3_0_01", run_v(4'd0, 4'd0, 4'd1));
    expect_at(c + 241, "t3_alarm_done", alarm_v(1'b1));
    expect_at(c + 242, "t3_alarm", alarm_v(1'b0));
    expect_at(c + 243, "t3_ack", IDLE_V);
    goto(c + 242);
    ack = 1'b1;
    step();
    ack = 1'b0; load = 1'b0;
    step();

    // pause holds digits and prescaler; tick coinciding with pause still applies
    set_time(4'd0, 4'd0, 4'd5); load = 1'b1; c = cyc;
    expect_at(c + 1, "t4_capture", run_v(4'd0, 4'd0, 4'd5));
    expect_at(c + 5, "t4_0_04", run_v(4'd0, 4'd0, 4'd4));
    goto(c + 6);
    pause_btn = 1'b1;
    expect_at(c + 7, "t4_paused", pause_v(4'd0, 4'd0, 4'd4));
    expect_at(c + 26, "t4_hold", pause_v(4'd0, 4'd0, 4'd4));
    step();
    pause_btn = 1'b0;
    goto(c + 27);
    pause_btn = 1'b1;
    expect_at(c + 28, "t4_resume", run_v(4'd0, 4'd0, 4'd4));
    expect_at(c + 29, "t4_resume_hold", run_v(4'd0, 4'd0, 4'd4));
    expect_at(c + 30, "t4_resume_dec", run_v(4'd0, 4'd0, 4'd3));
    step();
    pause_btn = 1'b0;
    goto(c + 33);
    pause_btn = 1'b1;
    expect_at(c + 34, "t4_tick_then_pause", pause_v(4'd0, 4'd0, 4'd2));
    expect_at(c + 40, "t4_hold2", pause_v(4'd0, 4'd0, 4'd2));
    step();
    pause_btn = 1'b0;
    goto(c + 40);
    load = 1'b0;
    step();

    // clamp on tens/units; cancel beats a same-cycle load edge
    set_time(4'd0, 4'd7, 4'd12); load = 1'b1; c = cyc;
    expect_at(c + 1, "t5_clamp", run_v(4'd0, 4'd5, 4'd9));
    expect_at(c + 2, "t5_clamp_hold", run_v(4'd0, 4'd5, 4'd9));
    goto(c + 2);
    load = 1'b0;
    step();
    load = 1'b1; cancel = 1'b1;
    expect_at(c + 4, "t5_cancel_wins", IDLE_V);
    expect_at(c + 6, "t5_stay_idle", IDLE_V);
    step();
    cancel = 1'b0;
    goto(c + 6);
    load = 1'b0;
    step();

    // reset in RUN; load held through reset restarts on release
    set_time(4'd0, 4'd0, 4'd3); load = 1'b1; c = cyc;
    expect_at(c + 1, "t6_capture", run_v(4'd0, 4'd0, 4'd3));
    step();
    reset = 1'b1;
    expect_at(c + 2, "t6_reset", IDLE_V);
    expect_at(c + 3, "t6_reset_hold", IDLE_V);
    step();
    step();
    reset = 1'b0;
    expect_at(c + 4, "t6_restart", run_v(4'd0, 4'd0, 4'd3));
    expect_at(c + 8, "t6_dec", run_v(4'd0, 4'd0, 4'd2));
    goto(c + 8);
    load = 1'b0;
    step();

    // minute clamp, then cancel from RUN
    set_time(4'd12, 4'd2, 4'd5); load = 1'b1; c = cyc;
    expect_at(c + 1, "t7_min_clamp", run_v(4'd9, 4'd2, 4'd5));
    expect_at(c + 5, "t7_dec", run_v(4'd9, 4'd2, 4'd4));
    goto(c + 5);
    cancel = 1'b1;
    expect_at(c + 6, "t7_cancel", IDLE_V);
    step();
    cancel = 1'b0; load = 1'b0;
    step();

    // pause on the tick reaching 0:00 -> alarm wins
    set_time(4'd0, 4'd0, 4'd1); load = 1'b1; c = cyc;
    expect_at(c + 1, "t8_capture", run_v(4'd0, 4'd0, 4'd1));
    goto(c + 4);
    pause_btn = 1'b1;
    expect_at(c + 4, "t8_pre_tick", run_v(4'd0, 4'd0, 4'd1));
    expect_at(c + 5, "t8_alarm_wins", alarm_v(1'b1));
    expect_at(c + 6, "t8_alarm", alarm_v(1'b0));
    step();
    pause_btn = 1'b0;
    goto(c + 6);
    cancel = 1'b1;
    expect_at(c + 7, "t8_cancel_alarm", IDLE_V);
    step();
    cancel = 1'b0; load = 1'b0;
    step();
    step();

    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
      n_checks += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
